// File: rtl/cache_types.sv
// cache_types: shared types and derived geometry for the instruction cache.
//   icache_state_t : fetch FSM states
//   refill_beat_t  : one memory return beat (valid, last, data)
//   ICACHE_*       : default geometry; offset_w/index_w/tag_w derive field widths
package cache_types;
   localparam int ICACHE_SETS       = 256;
   localparam int ICACHE_LINE_WORDS = 4;

   function automatic int offset_w(input int line_words);
      return $clog2(line_words * 4);
   endfunction

   function automatic int index_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int sets, input int line_words);
      return 32 - index_w(sets) - offset_w(line_words);
   endfunction

   localparam int ICACHE_OFFSET_W = offset_w(ICACHE_LINE_WORDS);
   localparam int ICACHE_INDEX_W  = index_w(ICACHE_SETS);
   localparam int ICACHE_TAG_W    = 32 - ICACHE_INDEX_W - ICACHE_OFFSET_W;

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MISS, S_REFILL} icache_state_t;

   typedef struct packed {
      logic        valid;
      logic        last;
      logic [31:0] data;
   } refill_beat_t;
endpackage

// File: rtl/icache_ram.sv
// icache_ram: tag + data array, synchronous read of a whole line, one write port.
//   clk               : clock
//   re_i, ridx_i      : read enable / set index; rtag_o, rline_o valid next cycle
//   we_i, widx_i      : write one data word (wword_i, wdata_i) into set widx_i
//   tag_we_i, wtag_i  : write the tag of set widx_i
// A read of the set being written returns the new contents so a refill can be
// looked up in the cycle right after its last beat.
module icache_ram
   import cache_types::*;
#(
   parameter int SETS       = ICACHE_SETS,
   parameter int LINE_WORDS = ICACHE_LINE_WORDS,
   parameter int TAG_W      = ICACHE_TAG_W
) (
   input  logic                                clk,
   input  logic                                re_i,
   input  logic [$clog2(SETS)-1:0]             ridx_i,
   output logic [TAG_W-1:0]                    rtag_o,
   output logic [LINE_WORDS-1:0][31:0]         rline_o,
   input  logic                                we_i,
   input  logic [$clog2(SETS)-1:0]             widx_i,
   input  logic [$clog2(LINE_WORDS)-1:0]       wword_i,
   input  logic [31:0]                         wdata_i,
   input  logic                                tag_we_i,
   input  logic [TAG_W-1:0]                    wtag_i
);
   localparam int WW = $clog2(LINE_WORDS);

   logic [TAG_W-1:0]            tag_mem  [SETS];
   logic [LINE_WORDS-1:0][31:0] data_mem [SETS];

   always_ff @(posedge clk) begin
      if (we_i) data_mem[widx_i][wword_i] <= wdata_i;
      if (tag_we_i) tag_mem[widx_i] <= wtag_i;
      if (re_i) begin
         rtag_o <= (tag_we_i && widx_i == ridx_i) ? wtag_i : tag_mem[ridx_i];
         for (int w = 0; w < LINE_WORDS; w++)
            rline_o[w] <= (we_i && widx_i == ridx_i && wword_i == WW'(w)) ? wdata_i : data_mem[ridx_i][w];
      end
   end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache returning 64-bit fetch packets.
//   clk, rst                    : clock, asynchronous active-high reset
//   pc_valid, pc, stall         : fetch request, accepted when pc_valid && !stall
//   flush, invalidate           : cancel outstanding fetch / clear all valid bits
//   inst_valid, inst            : packet {word at pc+4, word at pc} on a hit
//   rd_req, rd_addr, rd_ready   : line refill request handshake
//   ret_valid, ret_data, ret_last : refill beats, word 0 first
//   perf_hit_cnt, perf_miss_cnt : hit/miss counters, live only with ICACHE_PERF_EN
module icache
   import cache_types::*;
#(
   parameter int SETS       = ICACHE_SETS,
   parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_valid,
   input  logic [31:0] pc,
   input  logic        flush,
   input  logic        invalidate,
   output logic        inst_valid,
   output logic [63:0] inst,
   output logic        stall,
   output logic        rd_req,
   output logic [31:0] rd_addr,
   input  logic        rd_ready,
   input  logic        ret_valid,
   input  logic [31:0] ret_data,
   input  logic        ret_last,
   output logic [31:0] perf_hit_cnt,
   output logic [31:0] perf_miss_cnt
);
   localparam int OFF_W = offset_w(LINE_WORDS);
   localparam int IDX_W = index_w(SETS);
   localparam int TAG_W = tag_w(SETS, LINE_WORDS);
   localparam int WW    = $clog2(LINE_WORDS);

   icache_state_t              state_q;
   logic [31:0]                pc_q;
   logic [31:0]                rd_addr_q;
   logic [63:0]                inst_q;
   logic                       rd_req_q;
   logic                       flushed_q;
   logic                       inv_seen_q;
   logic                       replay_q;
   logic [WW-1:0]              cnt_q;
   logic [SETS-1:0]            valid_q;
   logic [TAG_W-1:0]           rd_tag;
   logic [LINE_WORDS-1:0][31:0] rd_line;
   refill_beat_t               beat;
   logic [IDX_W-1:0]           idx_q;
   logic [IDX_W-1:0]           ram_ridx;
   logic [WW-1:0]              w_lo;
   logic [WW-1:0]              w_hi;
   logic [63:0]                pkt;
   logic                       hit;
   logic                       accept;
   logic                       fire;
   logic                       fill_last;
   logic                       replay_go;
   logic                       ram_re;
   logic                       unused_bits;

   assign beat      = '{valid: ret_valid, last: ret_last, data: ret_data};
   assign idx_q     = pc_q[OFF_W +: IDX_W];
   assign hit       = state_q == S_LOOKUP && valid_q[idx_q] && rd_tag == pc_q[31 -: TAG_W];
   assign stall     = !(state_q == S_IDLE || (state_q == S_LOOKUP && (hit || flush)));
   assign accept    = pc_valid && !stall;
   assign fire      = hit && !flush;
   assign fill_last = state_q == S_REFILL && beat.valid && beat.last;
   // A flush seen anywhere after the handshake suppresses the replay lookup.
   assign replay_go = fill_last && !flushed_q && !flush;
   assign ram_re    = accept || replay_go;
   assign ram_ridx  = accept ? pc[OFF_W +: IDX_W] : idx_q;
   // pc_q[2] is always zero, so w_lo is the even word of the packet.
   assign w_lo      = pc_q[OFF_W-1:2];
   assign w_hi      = w_lo | WW'(1);
   assign pkt       = {rd_line[w_hi], rd_line[w_lo]};
   assign inst_valid = fire;
   assign inst      = fire ? pkt : inst_q;
   assign rd_req    = rd_req_q;
   assign rd_addr   = rd_addr_q;
   assign unused_bits = ^{pc[2:0], pc_q[2:0], replay_q};

   icache_ram #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)) u_ram (
      .clk      (clk),
      .re_i     (ram_re),
      .ridx_i   (ram_ridx),
      .rtag_o   (rd_tag),
      .rline_o  (rd_line),
      .we_i     (state_q == S_REFILL && beat.valid),
      .widx_i   (idx_q),
      .wword_i  (cnt_q),
      .wdata_i  (beat.data),
      .tag_we_i (fill_last),
      .wtag_i   (pc_q[31 -: TAG_W])
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         rd_addr_q  <= '0;
         inst_q     <= '0;
         rd_req_q   <= 1'b0;
         flushed_q  <= 1'b0;
         inv_seen_q <= 1'b0;
         replay_q   <= 1'b0;
         cnt_q      <= '0;
         valid_q    <= '0;
      end else begin
         if (fire) inst_q <= pkt;
         if (accept) begin
            pc_q     <= {pc[31:3], 3'b000};
            replay_q <= 1'b0;
         end
         // The missing set is dropped before its words are overwritten; a line
         // only becomes valid if no invalidate was seen during its refill.
         if (invalidate) valid_q <= '0;
         else if (state_q == S_LOOKUP && !hit && !flush) valid_q[idx_q] <= 1'b0;
         else if (fill_last && !inv_seen_q) valid_q[idx_q] <= 1'b1;
         case (state_q)
            S_IDLE: if (accept) state_q <= S_LOOKUP;
            S_LOOKUP:
               if (hit || flush) state_q <= accept ? S_LOOKUP : S_IDLE;
               else begin
                  state_q    <= S_MISS;
                  rd_req_q   <= 1'b1;
                  rd_addr_q  <= {pc_q[31:OFF_W], {OFF_W{1'b0}}};
                  inv_seen_q <= 1'b0;
               end
            S_MISS: begin
               if (invalidate) inv_seen_q <= 1'b1;
               if (rd_ready) begin
                  rd_req_q  <= 1'b0;
                  state_q   <= S_REFILL;
                  cnt_q     <= '0;
                  flushed_q <= flush;
               end else if (flush) begin
                  rd_req_q <= 1'b0;
                  state_q  <= S_IDLE;
               end
            end
            S_REFILL: begin
               if (invalidate) inv_seen_q <= 1'b1;
               if (flush) flushed_q <= 1'b1;
               if (beat.valid) cnt_q <= beat.last ? '0 : cnt_q + WW'(1);
               if (fill_last) begin
                  state_q  <= replay_go ? S_LOOKUP : S_IDLE;
                  replay_q <= 1'b1;
               end
            end
         endcase
      end
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (state_q == S_LOOKUP && !replay_q) begin
         if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
         else miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign perf_hit_cnt  = hit_cnt_q;
   assign perf_miss_cnt = miss_cnt_q;
`else
   assign perf_hit_cnt  = '0;
   assign perf_miss_cnt = '0;
`endif
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for icache.
module tb_icache;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pc_valid, flush, invalidate, rd_ready, ret_valid, ret_last;
   logic [31:0] pc, ret_data, rd_addr, perf_hit_cnt, perf_miss_cnt;
   logic        inst_valid, stall, rd_req;
   logic [63:0] inst;
   int          n_chk = 0;
   int          n_fail = 0;

`ifdef ICACHE_PERF_EN
   localparam logic [31:0] EXP_HITS = 32'd3, EXP_MISSES = 32'd1;
`else
   localparam logic [31:0] EXP_HITS = 32'd0, EXP_MISSES = 32'd0;
`endif

   icache dut (
      .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc), .flush(flush),
      .invalidate(invalidate), .inst_valid(inst_valid), .inst(inst), .stall(stall),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .ret_valid(ret_valid),
      .ret_data(ret_data), .ret_last(ret_last), .perf_hit_cnt(perf_hit_cnt),
      .perf_miss_cnt(perf_miss_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc;
      @(negedge clk);
      pc_valid = 0; pc = '0; flush = 0; invalidate = 0; rd_ready = 0;
      ret_valid = 0; ret_data = '0; ret_last = 0;
   endtask

   task automatic req(input logic [31:0] a);
      pc_valid = 1; pc = a;
   endtask

   task automatic miss_to_refill(input logic [31:0] a);
      cyc; req(a); #1;
      check("accept_stall", stall, 0);
      cyc; #1;
      check("miss_stall", stall, 1);
      check("miss_inst_valid", inst_valid, 0);
      cyc; #1;
      check("miss_rd_req", rd_req, 1);
      check("miss_rd_addr", rd_addr, a & ~32'hF);
      cyc; rd_ready = 1; #1;
      check("hold_rd_req", rd_req, 1);
      check("hold_rd_addr", rd_addr, a & ~32'hF);
   endtask

   task automatic refill(input logic [31:0] k, input int flush_beat, input bit inv_last);
      for (int i = 0; i < 4; i++) begin
         cyc;
         ret_valid = 1; ret_data = k * (i + 1); ret_last = (i == 3);
         flush = (i == flush_beat); invalidate = inv_last && (i == 3);
         #1;
         check("refill_stall", stall, 1);
         check("refill_rd_req", rd_req, 0);
         check("refill_inst_valid", inst_valid, 0);
      end
   endtask

   initial begin
      pc_valid = 0; pc = '0; flush = 0; invalidate = 0; rd_ready = 0;
      ret_valid = 0; ret_data = '0; ret_last = 0;
      #2 rst = 1; #1;
      check("rst_stall", stall, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_rd_req", rd_req, 0);
      check("rst_rd_addr", rd_addr, 0);
      @(negedge clk); rst = 0;

      // cold fetch and replay hit
      miss_to_refill(32'h1C000000);
      refill(32'h11, -1, 0);
      cyc; #1;
      check("cold_inst_valid", inst_valid, 1);
      check("cold_inst", inst, 64'h0000002200000011);
      check("cold_stall", stall, 0);

      // back-to-back hits
      cyc; req(32'h1C000008); #1;
      check("b2b_accept_stall", stall, 0);
      cyc; req(32'h1C000000); #1;
      check("hit1_valid", inst_valid, 1);
      check("hit1_inst", inst, 64'h0000004400000033);
      check("hit1_stall", stall, 0);
      check("hit1_rd_req", rd_req, 0);
      cyc; #1;
      check("hit2_valid", inst_valid, 1);
      check("hit2_inst", inst, 64'h0000002200000011);
      check("hit2_stall", stall, 0);
      check("hit2_rd_req", rd_req, 0);

      // flush in MISS before handshake
      cyc; req(32'h1C000100); #1;
      cyc; #1;
      check("fm_miss_stall", stall, 1);
      cyc; flush = 1; #1;
      check("fm_rd_req", rd_req, 1);
      cyc; req(32'h1C000100); #1;
      check("fm_rd_req_drop", rd_req, 0);
      check("fm_idle_stall", stall, 0);
      cyc; #1;
      check("fm_still_invalid", stall, 1);
      cyc; flush = 1; #1;
      check("fm_rd_req2", rd_req, 1);

      // flush during REFILL beat 2: line installed, no replay
      miss_to_refill(32'h1C000200);
      refill(32'h01010101, 2, 0);
      cyc; #1;
      check("fr_no_inst", inst_valid, 0);
      check("fr_idle_stall", stall, 0);
      cyc; req(32'h1C000208); #1;
      cyc; #1;
      check("fr_hit_valid", inst_valid, 1);
      check("fr_hit_inst", inst, 64'h0404040403030303);
      check("fr_hit_rd_req", rd_req, 0);

      // invalidate together with ret_last
      miss_to_refill(32'h1C000300);
      refill(32'h05050505, -1, 1);
      cyc; #1;
      check("inv_replay_miss", stall, 1);
      check("inv_replay_inst_valid", inst_valid, 0);
      cyc; flush = 1; #1;
      check("inv_rd_req", rd_req, 1);
      check("inv_rd_addr", rd_addr, 32'h1C000300);
      miss_to_refill(32'h1C000300);
      refill(32'h06060606, -1, 0);
      cyc; #1;
      check("inv_refetch_valid", inst_valid, 1);
      check("inv_refetch_inst", inst, 64'h0C0C0C0C06060606);

      // reset in the middle of a refill
      miss_to_refill(32'h1C000400);
      cyc; ret_valid = 1; ret_data = 32'hAAAA0000; #1;
      cyc; ret_valid = 1; ret_data = 32'hAAAA0001; #1;
      cyc; rst = 1; #1;
      check("mid_rst_stall", stall, 0);
      check("mid_rst_inst_valid", inst_valid, 0);
      check("mid_rst_inst", inst, 0);
      check("mid_rst_rd_req", rd_req, 0);
      check("mid_rst_rd_addr", rd_addr, 0);
      check("mid_rst_hits", perf_hit_cnt, 0);
      check("mid_rst_misses", perf_miss_cnt, 0);
      cyc; rst = 0;

      // stray beat outside REFILL must not shift the word counter
      cyc; ret_valid = 1; ret_data = 32'hDEADBEEF; ret_last = 1; #1;
      miss_to_refill(32'h1C000400);
      refill(32'h07070707, -1, 0);
      cyc; #1;
      check("post_rst_inst", inst, 64'h0E0E0E0E07070707);
      cyc; req(32'h1C000400); #1;
      cyc; req(32'h1C000408); #1;
      check("p_hit1", inst, 64'h0E0E0E0E07070707);
      cyc; req(32'h1C000400); #1;
      check("p_hit2", inst, 64'h1C1C1C1C15151515);
      cyc; #1;
      check("p_hit3", inst, 64'h0E0E0E0E07070707);
      check("p_hit3_valid", inst_valid, 1);
      cyc; #1;
      check("perf_hit_cnt", perf_hit_cnt, EXP_HITS);
      check("perf_miss_cnt", perf_miss_cnt, EXP_MISSES);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
